// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// FSM states, supported opcodes and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_JAL       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_BNE || op == OP_ADDI ||
               op == OP_J || op == OP_JAL;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the shared multi-cycle MIPS datapath, with a
// retired-instruction counter and a sticky illegal-opcode flag.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count,
    output logic               illegal
);

    state_t state_q;
    state_t state_d;
    logic   retire;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDI_EXEC;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH,
            S_ADDI_WB, S_JUMP, S_JAL: state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them at once.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        pc_source  = PCSRC_ALU;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE:    alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = DST_RD;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_en     = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_ADDI_WB:   reg_write = 1'b1;
            S_JUMP: begin
                pc_en     = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                pc_en      = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = DST_RA;
                mem_to_reg = M2R_PC;
            end
            default: ;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            unique case (state_q)
                S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH,
                S_ADDI_WB, S_JUMP, S_JAL: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            if (retire)
                instr_count <= instr_count + COUNT_W'(1);
            if (state_q == S_DECODE && !is_legal(opcode))
                illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected state/strobes are queued by the
// stimulus process and compared by an independent monitor.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic        alu_src_a;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic        illegal;

    mips_multicycle_ctrl #(.COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_count(instr_count),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pc_en,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,
    //  mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_source}
    localparam logic [16:0] C_IDLE  = 17'b0_0_0_0_0_0_00_00_0_00_00_00;
    localparam logic [16:0] C_F_RDY = 17'b1_0_1_0_1_0_00_00_0_01_00_00;
    localparam logic [16:0] C_F_WT  = 17'b0_0_1_0_0_0_00_00_0_01_00_00;
    localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_00_00_0_11_00_00;
    localparam logic [16:0] C_MADDR = 17'b0_0_0_0_0_0_00_00_1_10_00_00;
    localparam logic [16:0] C_MRD   = 17'b0_1_1_0_0_0_00_00_0_00_00_00;
    localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_1_00_01_0_00_00_00;
    localparam logic [16:0] C_MWR   = 17'b0_1_0_1_0_0_00_00_0_00_00_00;
    localparam logic [16:0] C_EXE   = 17'b0_0_0_0_0_0_00_00_1_00_10_00;
    localparam logic [16:0] C_AWB   = 17'b0_0_0_0_0_1_01_00_0_00_00_00;
    localparam logic [16:0] C_BR_T  = 17'b1_0_0_0_0_0_00_00_1_00_01_01;
    localparam logic [16:0] C_BR_N  = 17'b0_0_0_0_0_0_00_00_1_00_01_01;
    localparam logic [16:0] C_IWB   = 17'b0_0_0_0_0_1_00_00_0_00_00_00;
    localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_00_00_0_00_00_10;
    localparam logic [16:0] C_JAL   = 17'b1_0_0_0_0_1_10_10_0_00_00_10;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [31:0] cnt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int tag = 0;

    logic [16:0] ctl_now;
    assign ctl_now = {pc_en, iord, mem_read, mem_write, ir_write, reg_write,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                      pc_source};

    task automatic step(input logic rst, input logic [5:0] op,
                        input logic mr, input logic z, input logic [3:0] st,
                        input logic [16:0] ctl, input logic [31:0] cnt,
                        input logic ill);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = cnt;
        e.ill = ill;
        e.tag = 8'(tag);
        tag++;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (state !== e.st) begin
                    failures++;
                    $display("FAIL state cyc%0d got=%0d exp=%0d", e.tag, state, e.st);
                end
                checks++;
                if (ctl_now !== e.ctl) begin
                    failures++;
                    $display("FAIL strobes cyc%0d got=%b exp=%b", e.tag, ctl_now, e.ctl);
                end
                checks++;
                if (instr_count !== e.cnt) begin
                    failures++;
                    $display("FAIL instr_count cyc%0d got=%0d exp=%0d", e.tag, instr_count, e.cnt);
                end
                checks++;
                if (illegal !== e.ill) begin
                    failures++;
                    $display("FAIL illegal cyc%0d got=%0b exp=%0b", e.tag, illegal, e.ill);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset held, then released: IDLE for one cycle
        step(0, 6'h00, 1, 0, 4'd0, C_IDLE, 0, 0);
        step(1, 6'h00, 1, 0, 4'd0, C_IDLE, 0, 0);
        // R-type: 1,2,7,8
        step(1, 6'h00, 1, 0, 4'd1, C_F_RDY, 0, 0);
        step(1, 6'h00, 1, 0, 4'd2, C_DEC,   0, 0);
        step(1, 6'h00, 1, 0, 4'd7, C_EXE,   0, 0);
        step(1, 6'h00, 1, 0, 4'd8, C_AWB,   0, 0);
        // lw with two wait cycles in MEM_READ
        step(1, 6'h23, 1, 0, 4'd1, C_F_RDY, 1, 0);
        step(1, 6'h23, 1, 0, 4'd2, C_DEC,   1, 0);
        step(1, 6'h23, 0, 0, 4'd3, C_MADDR, 1, 0);
        step(1, 6'h23, 0, 0, 4'd4, C_MRD,   1, 0);
        step(1, 6'h23, 0, 0, 4'd4, C_MRD,   1, 0);
        step(1, 6'h23, 1, 0, 4'd4, C_MRD,   1, 0);
        step(1, 6'h23, 1, 0, 4'd5, C_MWB,   1, 0);
        // beq taken, bne not taken with zero=1
        step(1, 6'h04, 1, 1, 4'd1, C_F_RDY, 2, 0);
        step(1, 6'h04, 1, 1, 4'd2, C_DEC,   2, 0);
        step(1, 6'h04, 1, 1, 4'd9, C_BR_T,  2, 0);
        step(1, 6'h05, 1, 1, 4'd1, C_F_RDY, 3, 0);
        step(1, 6'h05, 1, 1, 4'd2, C_DEC,   3, 0);
        step(1, 6'h05, 1, 1, 4'd9, C_BR_N,  3, 0);
        // jal, mem_ready low in DECODE must be ignored
        step(1, 6'h03, 1, 0, 4'd1,  C_F_RDY, 4, 0);
        step(1, 6'h03, 0, 0, 4'd2,  C_DEC,   4, 0);
        step(1, 6'h03, 0, 0, 4'd13, C_JAL,   4, 0);
        // illegal opcode: back to FETCH, not counted, flag sticky
        step(1, 6'h3F, 1, 0, 4'd1, C_F_RDY, 5, 0);
        step(1, 6'h3F, 1, 0, 4'd2, C_DEC,   5, 0);
        // addi with one FETCH wait
        step(1, 6'h08, 0, 0, 4'd1,  C_F_WT,  5, 1);
        step(1, 6'h08, 1, 0, 4'd1,  C_F_RDY, 5, 1);
        step(1, 6'h08, 1, 0, 4'd2,  C_DEC,   5, 1);
        step(1, 6'h08, 1, 0, 4'd11, C_MADDR, 5, 1);
        step(1, 6'h08, 1, 0, 4'd12, C_IWB,   5, 1);
        // j
        step(1, 6'h02, 1, 0, 4'd1,  C_F_RDY, 6, 1);
        step(1, 6'h02, 1, 0, 4'd2,  C_DEC,   6, 1);
        step(1, 6'h02, 1, 0, 4'd10, C_JMP,   6, 1);
        // sw: one full store, then a second aborted by reset
        step(1, 6'h2B, 1, 0, 4'd1, C_F_RDY, 7, 1);
        step(1, 6'h2B, 1, 0, 4'd2, C_DEC,   7, 1);
        step(1, 6'h2B, 1, 0, 4'd3, C_MADDR, 7, 1);
        step(1, 6'h2B, 1, 0, 4'd6, C_MWR,   7, 1);
        step(1, 6'h2B, 1, 0, 4'd1, C_F_RDY, 8, 1);
        step(1, 6'h2B, 1, 0, 4'd2, C_DEC,   8, 1);
        step(1, 6'h2B, 0, 0, 4'd3, C_MADDR, 8, 1);
        step(1, 6'h2B, 0, 0, 4'd6, C_MWR,   8, 1);
        // async reset mid-store: sampled before any clock edge
        step(0, 6'h2B, 0, 0, 4'd0, C_IDLE,  0, 0);
        step(1, 6'h00, 1, 0, 4'd0, C_IDLE,  0, 0);
        step(1, 6'h00, 1, 0, 4'd1, C_F_RDY, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencing controller for the MIPS datapath (program counter, instruction memory/IR, register file, ALU). A Moore state machine decodes the fetched opcode. It steps the shared datapath through fetch, decode, execute, memory and write-back phases, stretching memory phases with a ready handshake. It also keeps a retired-instruction counter and a sticky illegal-opcode flag that the bench reads at end of run.

## Interface
- COUNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC load enable
- iord  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_write  out  1  register-file write enable
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $ra (31)
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (jal)
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- state  out  4  current state encoding (debug)
- instr_count  out  COUNT_W  retired instructions
- illegal  out  1  sticky: unsupported opcode seen

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, ALU_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12, JAL 13.
- IDLE: all outputs 0. Always goes to FETCH next cycle.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. ir_write and pc_en are asserted only while mem_ready=1. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXECUTE
  - 0x23, 0x2B → MEM_ADDR
  - 0x04, 0x05 → BRANCH
  - 0x08 → ADDI_EXEC
  - 0x02 → JUMP
  - 0x03 → JAL
  - any other opcode → sets illegal, goes to FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=0, alu_op=2. Then ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1. pc_en = zero for beq, ~zero for bne. Then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- JUMP: pc_en=1, pc_source=2. Then FETCH.
- JAL: pc_en=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. PC already holds PC+4. Then FETCH.
- Outputs not listed for a state are 0.
- instr_count increments by 1 in the cycle the FSM leaves a terminal state into FETCH. Terminal states: MEM_WB, MEM_WRITE (on mem_ready), ALU_WB, BRANCH, ADDI_WB, JUMP, JAL. Wraps modulo 2^COUNT_W. Illegal opcodes are not counted.
- illegal is set in DECODE on an unsupported opcode and cleared only by reset.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, instr_count=0, illegal=0, all strobes 0. The first FETCH occurs 1 cycle after rst_n rises.
- Reset asserted mid-instruction aborts immediately. No partial write strobe survives the edge.
- With mem_ready held at 1, cycles per instruction:
  - R-type 4, lw 5, sw 4, addi 4
  - beq/bne 3, j 3, jal 3
- Each low cycle of mem_ready in FETCH, MEM_READ or MEM_WRITE adds exactly 1 cycle. Strobes stay steady while waiting.
- mem_ready is ignored in all other states.
- Strobes are pure functions of the state register and inputs (zero, mem_ready, opcode in BRANCH). There are no registered outputs, so there is no extra latency.

## Structure
- Shared package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL)
  - alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg select codes
- Single module, no sub-modules. Next-state logic, output decode and counter/flag registers sit in separate always blocks.

## Test plan
- Reset, then R-type (opcode 0x00) with mem_ready=1 → states 0,1,2,7,8,1. reg_write=1 and reg_dst=1 in cycle 4 of the instruction. instr_count=1.
- lw, with mem_ready low for 2 cycles in MEM_READ → lw takes 7 cycles. mem_read and iord held through the wait. MEM_WB asserts mem_to_reg=1.
- beq with zero=1, then bne with zero=1 → pc_en=1 in BRANCH for beq, pc_en=0 for bne. Both take 3 cycles. instr_count advances by 2.
- jal → single JAL cycle with pc_en=1, reg_write=1, reg_dst=2, mem_to_reg=2.
- Opcode 0x3F → illegal rises in DECODE and stays high. FSM returns to FETCH and instr_count is unchanged.
- rst_n pulsed low during MEM_WRITE → mem_write drops asynchronously. state=IDLE, instr_count=0, illegal=0.
